// File: rtl/lt_gamma_sched_if.sv
// Host-side handshake bundle for lt_gamma_sched.
//   in_valid/in_ready   : operand-pair handshake (host -> sequencer)
//   in_a, in_a_inf      : operand a edge time, or never (inf)
//   in_b, in_b_inf      : operand b edge time, or never (inf)
//   out_valid/out_ready : result handshake (sequencer -> host)
//   res_time, res_inf   : decoded q edge time, or no edge in the window
// The slave modport is the sequencer side; master is the host side.
interface lt_gamma_sched_if #(
    parameter int unsigned VAL_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [VAL_W-1:0] in_a;
    logic             in_a_inf;
    logic [VAL_W-1:0] in_b;
    logic             in_b_inf;
    logic             out_valid;
    logic             out_ready;
    logic [VAL_W-1:0] res_time;
    logic             res_inf;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_a,
        input  in_a_inf,
        input  in_b,
        input  in_b_inf,
        output out_valid,
        input  out_ready,
        output res_time,
        output res_inf
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_a,
        output in_a_inf,
        output in_b,
        output in_b_inf,
        input  out_valid,
        output out_ready,
        input  res_time,
        input  res_inf
    );
endinterface

// File: rtl/lt_gamma_sched.sv
// Sequencer for one rising-edge less_than race-logic unit.
// Accepts an operand pair, pulses the unit's set, drives each operand as a rising step at its
// edge time inside a GAMMA_CYCLE_WIDTH-cycle window, records the first cycle q was sampled high
// and returns that time (or inf) over a valid/ready handshake.
// Ports:
//   aclk, grst : clock; synchronous active-high reset
//   host       : lt_gamma_sched_if slave (operand and result handshakes)
//   lt_set     : unit set pulse (one cycle before the window)
//   lt_a, lt_b : unit operand inputs (monotonic steps within the window)
//   lt_q       : unit output, sampled at the edge closing each window cycle
//   busy       : sequencer is not idle
// All outputs are registered.
module lt_gamma_sched #(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic              aclk,
    input  logic              grst,
    lt_gamma_sched_if.slave   host,
    output logic              lt_set,
    output logic              lt_a,
    output logic              lt_b,
    input  logic              lt_q,
    output logic              busy
);

    if (GAMMA_CYCLE_WIDTH < 2) begin : g_bad_gamma
        $error("GAMMA_CYCLE_WIDTH must be at least 2");
    end
    // The unit's q pulse length does not matter here: only the first high sample counts.
    if (PULSE_WIDTH < 1) begin : g_bad_pulse
        $error("PULSE_WIDTH must be at least 1");
    end

    // One extra bit so the t >= a compare at the last window cycle cannot wrap.
    localparam int unsigned TW = VAL_W + 1;
    localparam logic [TW-1:0] TLast = TW'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSet,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [TW-1:0]    t_q, t_d;
    logic [VAL_W-1:0] a_q, a_d;
    logic [VAL_W-1:0] b_q, b_d;
    logic             a_inf_q, a_inf_d;
    logic             b_inf_q, b_inf_d;

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             lt_set_q, lt_set_d;
    logic             lt_a_q, lt_a_d;
    logic             lt_b_q, lt_b_d;
    logic [VAL_W-1:0] res_time_q, res_time_d;
    logic             res_inf_q, res_inf_d;
    logic             busy_q, busy_d;

    logic             run_d;

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        a_d        = a_q;
        b_d        = b_q;
        a_inf_d    = a_inf_q;
        b_inf_d    = b_inf_q;
        res_time_d = res_time_q;
        res_inf_d  = res_inf_q;

        unique case (state_q)
            StIdle: begin
                if (host.in_valid && in_ready_q) begin
                    a_d        = host.in_a;
                    a_inf_d    = host.in_a_inf;
                    b_d        = host.in_b;
                    b_inf_d    = host.in_b_inf;
                    // Result starts as "no edge seen" for the coming window.
                    res_time_d = '0;
                    res_inf_d  = 1'b1;
                    state_d    = StSet;
                end
            end
            StSet: begin
                t_d     = '0;
                state_d = StRun;
            end
            StRun: begin
                // res_inf_q still high means q has not been seen high yet in this window.
                if (lt_q && res_inf_q) begin
                    res_time_d = t_q[VAL_W-1:0];
                    res_inf_d  = 1'b0;
                end
                if (t_q == TLast) begin
                    state_d = StDone;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            StDone: begin
                if (host.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs are derived from the state being entered so that they line up
    // with that state's cycle.
    always_comb begin
        run_d       = (state_d == StRun);
        in_ready_d  = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        lt_set_d    = (state_d == StSet);
        out_valid_d = (state_d == StDone);
        lt_a_d      = run_d && !a_inf_d && (t_d >= {1'b0, a_d});
        lt_b_d      = run_d && !b_inf_d && (t_d >= {1'b0, b_d});
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q     <= StIdle;
            t_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            a_inf_q     <= 1'b0;
            b_inf_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            lt_set_q    <= 1'b0;
            lt_a_q      <= 1'b0;
            lt_b_q      <= 1'b0;
            res_time_q  <= '0;
            res_inf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_inf_q     <= a_inf_d;
            b_inf_q     <= b_inf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            lt_set_q    <= lt_set_d;
            lt_a_q      <= lt_a_d;
            lt_b_q      <= lt_b_d;
            res_time_q  <= res_time_d;
            res_inf_q   <= res_inf_d;
            busy_q      <= busy_d;
        end
    end

    assign host.in_ready  = in_ready_q;
    assign host.out_valid = out_valid_q;
    assign host.res_time  = res_time_q;
    assign host.res_inf   = res_inf_q;
    assign lt_set         = lt_set_q;
    assign lt_a           = lt_a_q;
    assign lt_b           = lt_b_q;
    assign busy           = busy_q;

endmodule
